tt_logic_unit_pipe: RTL and testbench
=====================================

Name: tt_logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8-bit combinational AND block used behind the tile wrapper.
- Takes two WIDTH-bit operands plus an opcode through a valid/ready handshake.
- Computes one of eight logic/arithmetic functions, optionally against an internal accumulator.
- Returns a registered result with zero/carry flags after two cycles, under full backpressure.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..32).
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  unit accepts operand this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  function select
- acc_en  input  1  substitute accumulator for B on this transaction
- acc_clr  input  1  synchronous accumulator clear
- out_valid  output  1  result held on Y/flags
- out_ready  input  1  downstream consumes result
- y  output  WIDTH  result
- zero  output  1  y == 0
- carry  output  1  carry-out of ADD; 0 for other ops
- txn_count  output  CNT_W  number of results consumed

Behaviour:
- Reset: asynchronous, active-high; clears all state immediately.
  - Outputs: out_valid=0, y=0, zero=0, carry=0, txn_count=0.
  - Internal: stage-1 valid=0, accumulator=0.
  - in_ready=1 whenever stage 1 is empty.
- Stage 1 (operand register): captures {a, b, op, acc_en} when in_valid && in_ready. No other input affects stage 1.
- Stage 2 (output register): load condition s2_load = !out_valid || out_ready.
  - On an s2_load edge, out_valid takes the stage-1 valid bit.
  - y, zero and carry update only when the stage-1 valid bit is 1.
- Backpressure: in_ready = !s1_valid || s2_load. This is combinational from out_ready and gives full throughput (one result per cycle while out_ready=1).
- Hold: while out_valid && !out_ready, the values on y, zero and carry are held stable.
- Latency: a transaction accepted at edge N has out_valid=1 after edge N+1 when unstalled. That is two register stages: operand in at edge N, result out at edge N+1.
- Operand select: in stage 2, B' = s1_acc_en ? acc : s1_b.
- Functions (op):
  - 0 AND
  - 1 OR
  - 2 XOR
  - 3 NAND
  - 4 NOR
  - 5 XNOR
  - 6 ADD (A+B' mod 2^WIDTH; carry = bit WIDTH of the sum)
  - 7 PASS A
- Flags: carry=0 for every op except 6. zero computed on the truncated WIDTH-bit result.
- Accumulator: loads the computed result on every s2_load edge that carries a valid stage-1 transaction with s1_acc_en=1.
  - Because B' reads acc in stage 2, back-to-back accumulate transactions chain with no hazard.
  - acc_clr=1 sets acc=0 on the next edge and wins over a same-cycle accumulator load.
  - acc_clr has no effect on y or on in-flight data.
- txn_count: increments on each edge where out_valid && out_ready; wraps from 2^CNT_W-1 to 0.
- Simultaneous accept and drain: accept, stage advance and consume in the same cycle are all legal; no bubble is inserted.
- Reset asserted mid-operation: both in-flight transactions are discarded and the accumulator is lost. After release, the first accepted transaction produces out_valid two edges later.
- in_valid=0: stage 1 empties on the next s2_load; y retains its last value while out_valid=0.

Test Plan:
- Reset then single AND (WIDTH=8): a=0xF0, b=0x3C, op=0, out_ready=1 -> after 2 edges out_valid=1, y=0x30, zero=0, carry=0, then txn_count=1.
- ADD carry/zero: a=0xFF, b=0x01, op=6 -> y=0x00, zero=1, carry=1. Then a=0x7F, b=0x01 -> y=0x80, carry=0.
- Streaming all ops: a=0xA5, b=0x0F, op=0..7 on consecutive cycles, out_ready=1 -> y sequence is 0x05, 0xAF, 0xAA, 0xFA, 0x50, 0x55, 0xB4, 0xA5 on consecutive cycles; in_ready stays 1.
- Backpressure: stream 4 ADDs with out_ready held 0 for 3 cycles -> in_ready drops after 2 accepts, y holds the first result, and no transaction is lost or duplicated. Releasing out_ready yields all 4 in order; txn_count=4.
- Accumulate chain: acc_clr pulse, then four transactions a=0x10, op=6, acc_en=1 back-to-back -> y = 0x10, 0x20, 0x30, 0x40. Then acc_clr coincident with an accumulate transaction's stage-2 load -> acc=0 afterwards, and the next acc_en ADD with a=0x05 gives y=0x05.
- Async reset mid-stream: assert reset between clock edges with 2 transactions in flight -> out_valid, y and txn_count go to 0 immediately without a clock edge. Post-release, a=0x0F, b=0xF0, op=1 gives y=0xFF two edges after accept.

Source files
------------

// File: rtl/tt_logic_unit_pipe_if.sv
// Purpose: operand/result handshake bundle for tt_logic_unit_pipe.
// Latency: none; this file only groups wires.
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
// Ports: master drives operands and out_ready; slave (the unit) drives
//        in_ready, result, flags and the consumed-transaction count.
interface tt_logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             carry;
    logic [CNT_W-1:0] txn_count;

    modport master (
        output in_valid, a, b, op, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, y, zero, carry, txn_count
    );

    modport slave (
        input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, y, zero, carry, txn_count
    );
endinterface

// File: rtl/tt_logic_unit_pipe.sv
// Purpose: two-stage logic/ADD unit with optional accumulator operand.
// Latency: accepted at edge N, result valid after edge N+1 (full throughput).
// Backpressure: in_ready = !s1_valid || s2_load, combinational from out_ready.
// Ports: clk, reset (async, active-high), bus (slave modport): operands
//        a/b/op/acc_en/acc_clr in, y/zero/carry/txn_count out.
module tt_logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    tt_logic_unit_pipe_if.slave  bus
);
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ADD  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // Stage 1: captured operands
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_acc_en;

    // Stage 2: registered result
    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] acc;

    logic             s2_load;
    logic             s1_ready;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_carry;

    assign s2_load  = !out_valid_q || bus.out_ready;
    assign s1_ready = !s1_valid || s2_load;

    assign bus.in_ready  = s1_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.txn_count = cnt_q;

    // The accumulator is read here, at stage-2 time, so an accumulate
    // transaction sitting in stage 1 sees the result of the one just ahead.
    always_comb begin
        b_sel     = s1_acc_en ? acc : s1_b;
        sum       = {1'b0, s1_a} + {1'b0, b_sel};
        res       = '0;
        res_carry = 1'b0;
        case (s1_op)
            OP_AND:  res = s1_a & b_sel;
            OP_OR:   res = s1_a | b_sel;
            OP_XOR:  res = s1_a ^ b_sel;
            OP_NAND: res = ~(s1_a & b_sel);
            OP_NOR:  res = ~(s1_a | b_sel);
            OP_XNOR: res = ~(s1_a ^ b_sel);
            OP_ADD: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
            end
            OP_PASS: res = s1_a;
            default: res = s1_a;
        endcase
    end

    // Stage 1 advances (fills or empties) whenever it can hand its contents on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            s1_acc_en <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a      <= bus.a;
                s1_b      <= bus.b;
                s1_op     <= bus.op;
                s1_acc_en <= bus.acc_en;
            end
        end
    end

    // Result fields only move on a real transaction so y holds across bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                y_q     <= res;
                zero_q  <= (res == '0);
                carry_q <= res_carry;
            end
        end
    end

    // Clear has priority over a coincident accumulate load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (bus.acc_clr) begin
            acc <= '0;
        end else if (s2_load && s1_valid && s1_acc_en) begin
            acc <= res;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_tt_logic_unit_pipe.sv
// Purpose: self-checking bench for tt_logic_unit_pipe (WIDTH=8, CNT_W=16).
// Latency: drives one step per clock, samples 1-2 time units after the edge.
// Backpressure: out_ready is driven per step; a result queue tracks in-flight work.
module tb_tt_logic_unit_pipe;
    localparam int W  = 8;
    localparam int CW = 16;

    typedef struct packed {
        logic [W-1:0] y;
        logic         z;
        logic         c;
    } res_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tt_logic_unit_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    tt_logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    res_t         q[$];
    int           total = 0;
    int           bad = 0;
    int           consumed = 0;
    logic [W-1:0] macc = '0;
    bit           hold_pending = 0;
    logic [W-1:0] hold_y = '0;

    logic [W-1:0] tbl[8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hB4, 8'hA5};
    logic [W-1:0] ba[4]  = '{8'h11, 8'h80, 8'h01, 8'hF0};
    logic [W-1:0] bb[4]  = '{8'h22, 8'h80, 8'h02, 8'h20};

    // Reference: the function table written as plain arithmetic.
    function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [2:0] op);
        res_t r;
        int   s;
        r.c = 1'b0;
        case (op)
            3'd0: r.y = a & b;
            3'd1: r.y = a | b;
            3'd2: r.y = a ^ b;
            3'd3: r.y = ~(a & b);
            3'd4: r.y = ~(a | b);
            3'd5: r.y = ~(a ^ b);
            3'd6: begin
                s   = int'(a) + int'(b);
                r.y = W'(s % (1 << W));
                r.c = (s >= (1 << W));
            end
            default: r.y = a;
        endcase
        r.z = (r.y == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check what the model predicts for this cycle,
    // update the model with any accept, then let the edge happen.
    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [2:0] iop, input logic ien, input logic iclr,
                        input logic ior, output logic accepted);
        res_t         e;
        logic [W-1:0] bp;
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.op        = iop;
        bus.acc_en    = ien;
        bus.acc_clr   = iclr;
        bus.out_ready = ior;
        #1;
        chk("in_ready", bus.in_ready, (q.size() < 2) || ior);
        if (q.size() == 0) chk("idle_out_valid", bus.out_valid, 1'b0);
        if (q.size() == 2) chk("full_out_valid", bus.out_valid, 1'b1);
        if (hold_pending) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_y", bus.y, hold_y);
        end
        if (bus.out_valid && ior) begin
            chk("result_pending", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("y", bus.y, e.y);
                chk("zero", bus.zero, e.z);
                chk("carry", bus.carry, e.c);
                consumed++;
            end
        end
        hold_pending = bus.out_valid && !ior;
        hold_y       = bus.y;
        if (iclr) macc = '0;
        accepted = iv && bus.in_ready;
        if (accepted) begin
            bp = ien ? macc : ib;
            e  = ref_op(ia, bp, iop);
            q.push_back(e);
            if (ien) macc = e.y;
        end
        @(posedge clk);
        #1;
        chk("txn_count", bus.txn_count, CW'(consumed));
    endtask

    task automatic idle();
        logic acc;
        step(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && q.size() > 0; k++) idle();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   idx;
        int   cnt_before;
        logic iv, ien, iclr, ior;
        logic [W-1:0] ra, rb;
        logic [2:0]   rop;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.acc_en    = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_y", bus.y, 8'h00);
        chk("rst_zero", bus.zero, 1'b0);
        chk("rst_carry", bus.carry, 1'b0);
        chk("rst_txn_count", bus.txn_count, 16'd0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        reset = 1'b0;

        // Single AND
        step(1'b1, 8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0, 1'b1, acc);
        chk("and_not_yet", bus.out_valid, 1'b0);
        idle();
        chk("and_valid", bus.out_valid, 1'b1);
        chk("and_y", bus.y, 8'h30);
        chk("and_zero", bus.zero, 1'b0);
        chk("and_carry", bus.carry, 1'b0);
        idle();
        chk("and_txn", bus.txn_count, 16'd1);

        // ADD carry / zero
        step(1'b1, 8'hFF, 8'h01, 3'd6, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'h7F, 8'h01, 3'd6, 1'b0, 1'b0, 1'b1, acc);
        chk("add_ff_y", bus.y, 8'h00);
        chk("add_ff_zero", bus.zero, 1'b1);
        chk("add_ff_carry", bus.carry, 1'b1);
        idle();
        chk("add_7f_y", bus.y, 8'h80);
        chk("add_7f_carry", bus.carry, 1'b0);
        chk("add_7f_zero", bus.zero, 1'b0);
        drain();

        // Stream all ops back-to-back
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 8'hA5, 8'h0F, 3'(k), 1'b0, 1'b0, 1'b1, acc);
            chk("stream_accept", acc, 1'b1);
            if (k >= 1) chk("stream_y", bus.y, tbl[k-1]);
        end
        idle();
        chk("stream_y_last", bus.y, tbl[7]);
        drain();

        // Backpressure: out_ready low for the first 3 cycles
        cnt_before = consumed;
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            if (cyc == 3) chk("bp_two_accepts", idx, 2);
            step(1'b1, ba[idx], bb[idx], 3'd6, 1'b0, 1'b0, (cyc >= 3), acc);
            if (cyc == 2) chk("bp_y_first", bus.y, 8'h33);
            if (acc) idx++;
        end
        chk("bp_all_accepted", idx, 4);
        drain();
        chk("bp_txn_count", bus.txn_count, CW'(cnt_before + 4));

        // Accumulate chain
        step(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b1, acc);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 8'h10, 8'h00, 3'd6, 1'b1, 1'b0, 1'b1, acc);
            if (k >= 1) chk("acc_chain_y", bus.y, 8'(16 * k));
        end
        idle();
        chk("acc_chain_last", bus.y, 8'h40);
        step(1'b1, 8'h10, 8'h00, 3'd6, 1'b1, 1'b0, 1'b1, acc);
        step(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b1, acc);
        chk("acc_clr_same_load_y", bus.y, 8'h50);
        step(1'b1, 8'h05, 8'h00, 3'd6, 1'b1, 1'b0, 1'b1, acc);
        idle();
        chk("acc_after_clr_y", bus.y, 8'h05);
        drain();

        // Async reset with two transactions in flight
        step(1'b1, 8'h0F, 8'h0F, 3'd0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'h33, 8'h0F, 3'd1, 1'b0, 1'b0, 1'b1, acc);
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_y", bus.y, 8'h00);
        chk("arst_txn_count", bus.txn_count, 16'd0);
        q.delete();
        consumed     = 0;
        macc         = '0;
        hold_pending = 0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 8'h0F, 8'hF0, 3'd1, 1'b0, 1'b0, 1'b1, acc);
        chk("post_rst_not_yet", bus.out_valid, 1'b0);
        idle();
        chk("post_rst_valid", bus.out_valid, 1'b1);
        chk("post_rst_y", bus.y, 8'hFF);
        drain();

        // Randomised traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            ior  = ($urandom_range(0, 9) < 7);
            iv   = 1'($urandom_range(0, 1));
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rop  = 3'($urandom_range(0, 7));
            ien  = ($urandom_range(0, 3) == 0);
            iclr = ior && ($urandom_range(0, 7) == 0);
            step(iv, ra, rb, rop, ien, iclr, ior, acc);
        end
        drain();
        chk("final_txn_count", bus.txn_count, CW'(consumed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
